imem_fetch_responder: RTL and testbench
=======================================

Name: imem_fetch_responder

Overview:
- Instruction-memory responder on the fetch side of the single-cycle processor: accepts word-indexed program-counter fetch requests and returns the stored instruction after a fixed, parameterised latency.
- Valid/ready handshake on both the request and response channels.
- One request outstanding at a time.
- Includes a loader write port for preloading programs and a wrapping completed-fetch counter for bench/debug visibility.

Parameters:
- IMEM_DEPTH, 256, number of 32-bit instruction words.
- LATENCY, 2, cycles from request acceptance to first rsp_valid; legal range 1..7.
- NOP_INSTR, 32'h00000013, instruction returned on an out-of-range fetch.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- req_valid  input  1  fetch request present.
- req_ready  output  1  responder can accept a request this cycle.
- req_pc  input  32  word index of the instruction; the PC advances by 1 per instruction.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_instr  output  32  fetched instruction.
- rsp_pc  output  32  echo of the accepted req_pc.
- rsp_fault  output  1  req_pc >= IMEM_DEPTH.
- ld_en  input  1  loader write strobe.
- ld_addr  input  $clog2(IMEM_DEPTH)  loader word address.
- ld_data  input  32  loader write data.
- busy  output  1  state != IDLE.
- fetch_cnt  output  16  completed response handshakes, wraps 0xFFFF->0.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; rsp_valid=0; rsp_instr=0; rsp_pc=0; rsp_fault=0; fetch_cnt=0; busy=0.
  - Any pending fetch is dropped.
  - Memory contents are not cleared.
  - On reset release, the first acceptable edge is the next rising clk edge.
- FSM has three states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready:
    - Latch req_pc.
    - Read memory at that edge: rsp_fault = (req_pc >= IMEM_DEPTH); instruction = fault ? NOP_INSTR : mem[req_pc].
    - If LATENCY==1, go to RESP; otherwise go to WAIT with cnt=LATENCY-2.
  - WAIT: req_ready=0. Count cnt down; when cnt==0, go to RESP at the next edge.
  - RESP: rsp_valid=1. rsp_instr, rsp_pc and rsp_fault are held stable until rsp_valid&&rsp_ready.
    - On the handshake, fetch_cnt increments.
    - If req_valid is also high, the new request is accepted in the same cycle (req_ready = rsp_ready in RESP, a combinational path) and the FSM goes to WAIT, or stays in RESP if LATENCY==1.
    - Otherwise the FSM goes to IDLE.
- Latency and throughput:
  - A request accepted in cycle C gives rsp_valid first high in cycle C+LATENCY.
  - Back-to-back throughput is one fetch per LATENCY cycles when rsp_ready is held high.
- Read/write collision:
  - Read data is sampled at the acceptance edge.
  - If ld_en writes the same address in the acceptance cycle, the old data is returned (read-before-write).
  - Writes after acceptance do not affect the pending response.
- Loader:
  - ld_en writes are honoured in any state.
  - ld_addr is always in range by width.
- Out-of-range fetch: rsp_fault=1, rsp_instr=NOP_INSTR, rsp_pc = the full 32-bit req_pc. It is handshaken like a normal response.
- Backpressure: rsp_ready=0 holds RESP indefinitely; outputs do not change while held.
- fetch_cnt wraps silently.
- busy = (state != IDLE).

Test Plan:
- Reset then load: load mem[0..3]=32'h00500093, 32'h00A00113, 32'h002081B3, 32'h00000013. Fetch pc=0 with rsp_ready=1 and LATENCY=2 -> rsp_valid exactly 2 cycles after acceptance, rsp_instr=32'h00500093, rsp_pc=0, rsp_fault=0, fetch_cnt=1.
- Streaming: sequential pc 0..33 with req_valid and rsp_ready held high -> 34 responses in pc order, one every 2 cycles, fetch_cnt=34, no gaps after the first.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid on pc=2 -> rsp_instr stays 32'h002081B3 and req_ready=0 throughout. Releasing rsp_ready completes the handshake and fetch_cnt increments once.
- Out of range: fetch pc=256 -> rsp_fault=1, rsp_instr=32'h00000013, rsp_pc=256. A following pc=1 returns 32'h00A00113 with rsp_fault=0.
- Collision: ld_en writes mem[1]=32'hDEADBEEF in the same cycle pc=1 is accepted -> response is 32'h00A00113. The next fetch of pc=1 returns 32'hDEADBEEF.
- Reset mid-operation: assert reset during WAIT -> rsp_valid, busy and fetch_cnt drop to 0 immediately (asynchronously), no response emerges, and memory contents are retained (a post-reset pc=0 fetch still returns 32'h00500093).

Source files
------------

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder
//   Fetch-side instruction memory responder. Accepts one word-indexed PC
//   fetch at a time and returns the stored instruction LATENCY cycles after
//   acceptance, with valid/ready handshakes on both channels.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   req_valid  in   fetch request present
//   req_ready  out  request can be accepted this cycle
//   req_pc     in   32-bit word index of the instruction
//   rsp_valid  out  response present
//   rsp_ready  in   consumer accepts the response
//   rsp_instr  out  fetched instruction (NOP_INSTR on out-of-range fetch)
//   rsp_pc     out  echo of the accepted req_pc
//   rsp_fault  out  accepted req_pc was >= IMEM_DEPTH
//   ld_en      in   loader write strobe (honoured in every state)
//   ld_addr    in   loader word address
//   ld_data    in   loader write data
//   busy       out  FSM not idle
//   fetch_cnt  out  completed response handshakes, wraps silently

module imem_fetch_responder #(
    parameter int          IMEM_DEPTH = 256,
    parameter int          LATENCY    = 2,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic [31:0]                   req_pc,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [31:0]                   rsp_instr,
    output logic [31:0]                   rsp_pc,
    output logic                          rsp_fault,
    input  logic                          ld_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] ld_addr,
    input  logic [31:0]                   ld_data,
    output logic                          busy,
    output logic [15:0]                   fetch_cnt
);

    localparam int AW = $clog2(IMEM_DEPTH);

    // WAIT spends (cnt + 1) cycles, so LATENCY-2 preload yields LATENCY total.
    localparam logic [2:0] WAIT_INIT = 3'((LATENCY >= 2) ? (LATENCY - 2) : 0);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    logic [31:0] mem [IMEM_DEPTH];

    state_t     state;
    logic [2:0] cnt;
    logic       accept;
    logic       handshake;
    logic       fault;

    // In RESP a new request rides on the response handshake, so req_ready
    // follows rsp_ready combinationally there.
    assign req_ready = (state == IDLE) || ((state == RESP) && rsp_ready);
    assign accept    = req_valid && req_ready;
    assign handshake = rsp_valid && rsp_ready;
    assign fault     = (req_pc >= 32'(IMEM_DEPTH));

    // Memory has no reset so a preloaded program survives a reset pulse.
    always_ff @(posedge clk) begin
        if (ld_en) begin
            mem[ld_addr] <= ld_data;
        end
    end

    // Read is sampled at the acceptance edge; the non-blocking loader write
    // on the same edge is not yet visible, giving read-before-write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_instr <= '0;
            rsp_pc    <= '0;
            rsp_fault <= 1'b0;
            busy      <= 1'b0;
            fetch_cnt <= '0;
        end else begin
            if (handshake) begin
                fetch_cnt <= fetch_cnt + 16'd1;
            end

            if (accept) begin
                rsp_pc    <= req_pc;
                rsp_fault <= fault;
                rsp_instr <= fault ? NOP_INSTR : mem[req_pc[AW-1:0]];
                cnt       <= WAIT_INIT;
                busy      <= 1'b1;
                if (LATENCY == 1) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                end else begin
                    state     <= WAIT;
                    rsp_valid <= 1'b0;
                end
            end else begin
                unique case (state)
                    IDLE: begin
                        busy      <= 1'b0;
                        rsp_valid <= 1'b0;
                    end
                    WAIT: begin
                        if (cnt == '0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                        end else begin
                            cnt <= cnt - 3'd1;
                        end
                    end
                    RESP: begin
                        if (handshake) begin
                            state     <= IDLE;
                            rsp_valid <= 1'b0;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_imem_fetch_responder.sv
// tb_imem_fetch_responder
//   Self-checking bench for imem_fetch_responder. A transaction-level model
//   (outstanding request, due cycle, memory array) predicts handshake and
//   response behaviour; scenario tasks compare the DUT against it.

module tb_imem_fetch_responder;

    localparam int          DEPTH = 256;
    localparam int          LAT   = 2;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_pc;
    logic        rsp_fault;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        busy;
    logic [15:0] fetch_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] mmem [DEPTH];
    bit          m_out;
    int          m_due;
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic        m_fault;
    logic [15:0] m_cnt;
    int          cyc;
    logic        exp_valid;
    logic        exp_ready;

    imem_fetch_responder #(
        .IMEM_DEPTH (DEPTH),
        .LATENCY    (LAT),
        .NOP_INSTR  (NOP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_pc    (req_pc),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_instr (rsp_instr),
        .rsp_pc    (rsp_pc),
        .rsp_fault (rsp_fault),
        .ld_en     (ld_en),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .busy      (busy),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Called just after a falling edge: applies inputs and computes what the
    // model expects for this cycle.
    task automatic drive(input logic v, input logic [31:0] pc, input logic rr,
                         input logic le, input logic [7:0] la, input logic [31:0] ld);
        req_valid = v;
        req_pc    = pc;
        rsp_ready = rr;
        ld_en     = le;
        ld_addr   = la;
        ld_data   = ld;
        #1;
        exp_valid = m_out && (cyc >= m_due);
        exp_ready = !m_out || (exp_valid && rr);
    endtask

    // Applies this cycle's events to the model, then crosses the rising edge.
    task automatic advance();
        logic hs;
        logic acc;
        logic f;
        hs  = exp_valid && rsp_ready;
        acc = req_valid && exp_ready;
        if (acc) begin
            f       = (req_pc >= 32'(DEPTH));
            m_fault = f;
            m_pc    = req_pc;
            m_instr = f ? NOP : mmem[req_pc[7:0]];
            m_out   = 1'b1;
            m_due   = cyc + LAT;
        end else if (hs) begin
            m_out = 1'b0;
        end
        if (hs) m_cnt = m_cnt + 16'd1;
        if (ld_en) mmem[ld_addr] = ld_data;
        cyc = cyc + 1;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic apply_reset(input int n);
        #2;
        reset     = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        ld_en     = 1'b0;
        m_out     = 1'b0;
        m_cnt     = '0;
        repeat (n) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Issues one fetch from idle with rsp_ready high and reports what came back.
    task automatic do_fetch(input logic [31:0] pc, input logic le, input logic [7:0] la,
                            input logic [31:0] ld, output bit ok, output logic [31:0] instr,
                            output logic [31:0] rpc, output logic flt, output int lat);
        ok = 1'b0; lat = -1; instr = '0; rpc = '0; flt = 1'b0;
        drive(1'b1, pc, 1'b1, le, la, ld);
        advance();
        for (int k = 1; k <= 15; k++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0);
            if (rsp_valid === 1'b1) begin
                ok = 1'b1; lat = k; instr = rsp_instr; rpc = rsp_pc; flt = rsp_fault;
                advance();
                break;
            end
            advance();
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (fetch_cnt !== 16'd0) begin errors++; $display("FAIL reset_fetch_cnt got %h exp 0", fetch_cnt); end
        checks++; if (rsp_instr !== 32'd0) begin errors++; $display("FAIL reset_rsp_instr got %h exp 0", rsp_instr); end
        checks++; if (rsp_pc !== 32'd0) begin errors++; $display("FAIL reset_rsp_pc got %h exp 0", rsp_pc); end
        checks++; if (rsp_fault !== 1'b0) begin errors++; $display("FAIL reset_rsp_fault got %b exp 0", rsp_fault); end
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_req_ready got %b exp 1", req_ready); end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_load_first_fetch();
        logic [31:0] prog [4];
        logic [31:0] d;
        bit          ok;
        logic [31:0] instr;
        logic [31:0] rpc;
        logic        flt;
        int          lat;
        prog[0] = 32'h00500093; prog[1] = 32'h00A00113;
        prog[2] = 32'h002081B3; prog[3] = 32'h00000013;
        for (int a = 0; a < DEPTH; a++) begin
            d = (a < 4) ? prog[a] : $urandom;
            drive(1'b0, 32'd0, 1'b0, 1'b1, 8'(a), d);
            if (a == 100) begin
                checks++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin
                    errors++; $display("FAIL load_idle busy=%b rsp_valid=%b exp 0/0", busy, rsp_valid);
                end
            end
            advance();
        end
        do_fetch(32'd0, 1'b0, 8'd0, 32'd0, ok, instr, rpc, flt, lat);
        checks++; if (!ok || lat != LAT) begin errors++; $display("FAIL first_latency got %0d exp %0d", lat, LAT); end
        checks++; if (instr !== 32'h00500093) begin errors++; $display("FAIL first_instr got %h exp 00500093", instr); end
        checks++; if (rpc !== 32'd0 || flt !== 1'b0) begin errors++; $display("FAIL first_pc_fault got %h/%b exp 0/0", rpc, flt); end
        drive(1'b0, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0);
        checks++; if (fetch_cnt !== 16'd1) begin errors++; $display("FAIL first_fetch_cnt got %0d exp 1", fetch_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL first_busy_after got %b exp 0", busy); end
        advance();
    endtask

    task automatic test_streaming();
        logic [31:0] next_pc;
        int          got;
        int          last;
        logic        v;
        apply_reset(2);
        next_pc = 0; got = 0; last = -1;
        for (int t = 0; t < 200 && got < 34; t++) begin
            v = (next_pc < 34);
            drive(v, next_pc, 1'b1, 1'b0, 8'd0, 32'd0);
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL stream_req_ready got %b exp %b", req_ready, exp_ready); end
            checks++; if (rsp_valid !== exp_valid) begin errors++; $display("FAIL stream_rsp_valid got %b exp %b", rsp_valid, exp_valid); end
            if (exp_valid) begin
                checks++; if (rsp_pc !== 32'(got)) begin errors++; $display("FAIL stream_order got %0d exp %0d", rsp_pc, got); end
                checks++; if (rsp_instr !== m_instr) begin errors++; $display("FAIL stream_instr got %h exp %h", rsp_instr, m_instr); end
                if (last >= 0) begin
                    checks++; if (cyc - last != LAT) begin errors++; $display("FAIL stream_gap got %0d exp %0d", cyc - last, LAT); end
                end
                last = cyc;
                got++;
            end
            if (v && exp_ready) next_pc = next_pc + 1;
            advance();
        end
        checks++; if (got != 34) begin errors++; $display("FAIL stream_count got %0d exp 34", got); end
        drive(1'b0, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0);
        checks++; if (fetch_cnt !== 16'd34) begin errors++; $display("FAIL stream_fetch_cnt got %0d exp 34", fetch_cnt); end
        advance();
    endtask

    task automatic test_backpressure();
        bit          seen;
        logic [15:0] cnt0;
        seen = 1'b0;
        drive(1'b1, 32'd2, 1'b0, 1'b0, 8'd0, 32'd0);
        advance();
        for (int k = 0; k < 10; k++) begin
            drive(1'b1, 32'd5, 1'b0, 1'b0, 8'd0, 32'd0);
            if (rsp_valid === 1'b1) begin seen = 1'b1; break; end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_wait_req_ready got %b exp 0", req_ready); end
            advance();
        end
        checks++; if (!seen) begin errors++; $display("FAIL bp_timeout rsp_valid got 0 exp 1"); end
        cnt0 = m_cnt;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) drive(1'b1, 32'd5, 1'b0, 1'b0, 8'd0, 32'd0);
            checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got %b exp 1", rsp_valid); end
            checks++; if (rsp_instr !== 32'h002081B3 || rsp_pc !== 32'd2) begin
                errors++; $display("FAIL bp_hold_data got %h/%0d exp 002081b3/2", rsp_instr, rsp_pc);
            end
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_hold_req_ready got %b exp 0", req_ready); end
            checks++; if (fetch_cnt !== cnt0) begin errors++; $display("FAIL bp_hold_cnt got %0d exp %0d", fetch_cnt, cnt0); end
            advance();
        end
        drive(1'b0, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0);
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL bp_release_req_ready got %b exp 1", req_ready); end
        advance();
        drive(1'b0, 32'd0, 1'b0, 1'b0, 8'd0, 32'd0);
        checks++; if (fetch_cnt !== cnt0 + 16'd1) begin errors++; $display("FAIL bp_release_cnt got %0d exp %0d", fetch_cnt, cnt0 + 16'd1); end
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL bp_release_idle got %b/%b exp 0/0", rsp_valid, busy); end
        advance();
    endtask

    task automatic test_out_of_range();
        bit          ok;
        logic [31:0] instr;
        logic [31:0] rpc;
        logic        flt;
        int          lat;
        do_fetch(32'd256, 1'b0, 8'd0, 32'd0, ok, instr, rpc, flt, lat);
        checks++; if (!ok || flt !== 1'b1) begin errors++; $display("FAIL oor_fault got %b exp 1", flt); end
        checks++; if (instr !== NOP) begin errors++; $display("FAIL oor_instr got %h exp %h", instr, NOP); end
        checks++; if (rpc !== 32'd256) begin errors++; $display("FAIL oor_pc got %h exp 100", rpc); end
        do_fetch(32'hFFFF_FFF0, 1'b0, 8'd0, 32'd0, ok, instr, rpc, flt, lat);
        checks++; if (!ok || flt !== 1'b1 || rpc !== 32'hFFFF_FFF0 || instr !== NOP) begin
            errors++; $display("FAIL oor_high got %b/%h/%h exp 1/fffffff0/%h", flt, rpc, instr, NOP);
        end
        do_fetch(32'd1, 1'b0, 8'd0, 32'd0, ok, instr, rpc, flt, lat);
        checks++; if (!ok || instr !== 32'h00A00113 || flt !== 1'b0) begin
            errors++; $display("FAIL oor_follow got %h/%b exp 00a00113/0", instr, flt);
        end
    endtask

    task automatic test_collision();
        bit          ok;
        logic [31:0] instr;
        logic [31:0] rpc;
        logic        flt;
        int          lat;
        do_fetch(32'd1, 1'b1, 8'd1, 32'hDEADBEEF, ok, instr, rpc, flt, lat);
        checks++; if (!ok || instr !== 32'h00A00113) begin errors++; $display("FAIL collide_old got %h exp 00a00113", instr); end
        do_fetch(32'd1, 1'b0, 8'd0, 32'd0, ok, instr, rpc, flt, lat);
        checks++; if (!ok || instr !== 32'hDEADBEEF) begin errors++; $display("FAIL collide_new got %h exp deadbeef", instr); end
        // A write landing while the fetch is pending must not alter it.
        drive(1'b1, 32'd9, 1'b1, 1'b0, 8'd0, 32'd0);
        advance();
        drive(1'b0, 32'd0, 1'b0, 1'b1, 8'd9, ~mmem[9]);
        advance();
        drive(1'b0, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0);
        checks++; if (rsp_valid !== 1'b1 || rsp_instr !== m_instr) begin
            errors++; $display("FAIL collide_late got %b/%h exp 1/%h", rsp_valid, rsp_instr, m_instr);
        end
        advance();
    endtask

    task automatic test_random();
        logic        v;
        logic [31:0] pc;
        logic        rr;
        logic        le;
        for (int t = 0; t < 400; t++) begin
            v  = ($urandom_range(0, 3) != 0);
            pc = ($urandom_range(0, 7) == 0) ? 32'(DEPTH) + $urandom_range(0, 5000) : $urandom_range(0, DEPTH - 1);
            rr = ($urandom_range(0, 3) != 0);
            le = ($urandom_range(0, 2) == 0);
            drive(v, pc, rr, le, 8'($urandom_range(8, DEPTH - 1)), $urandom);
            checks++; if (req_ready !== exp_ready) begin errors++; $display("FAIL rand_req_ready t=%0d got %b exp %b", t, req_ready, exp_ready); end
            checks++; if (rsp_valid !== exp_valid) begin errors++; $display("FAIL rand_rsp_valid t=%0d got %b exp %b", t, rsp_valid, exp_valid); end
            checks++; if (busy !== m_out) begin errors++; $display("FAIL rand_busy t=%0d got %b exp %b", t, busy, m_out); end
            checks++; if (fetch_cnt !== m_cnt) begin errors++; $display("FAIL rand_fetch_cnt t=%0d got %0d exp %0d", t, fetch_cnt, m_cnt); end
            if (exp_valid) begin
                checks++; if (rsp_instr !== m_instr || rsp_pc !== m_pc || rsp_fault !== m_fault) begin
                    errors++; $display("FAIL rand_rsp t=%0d got %h/%h/%b exp %h/%h/%b",
                                       t, rsp_instr, rsp_pc, rsp_fault, m_instr, m_pc, m_fault);
                end
            end
            advance();
        end
        for (int k = 0; k < 20 && m_out; k++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0);
            advance();
        end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rand_drain busy got %b exp 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit          ok;
        logic [31:0] instr;
        logic [31:0] rpc;
        logic        flt;
        int          lat;
        drive(1'b1, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0);
        advance();
        drive(1'b0, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0);
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_wait got %b/%b exp 1/0", busy, rsp_valid); end
        #1;
        reset = 1'b0;
        m_out = 1'b0;
        m_cnt = '0;
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid got %b exp 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy); end
        checks++; if (fetch_cnt !== 16'd0) begin errors++; $display("FAIL mid_fetch_cnt got %0d exp 0", fetch_cnt); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        for (int k = 0; k < 5; k++) begin
            drive(1'b0, 32'd0, 1'b1, 1'b0, 8'd0, 32'd0);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got %b exp 0", rsp_valid); end
            advance();
        end
        do_fetch(32'd0, 1'b0, 8'd0, 32'd0, ok, instr, rpc, flt, lat);
        checks++; if (!ok || instr !== 32'h00500093 || flt !== 1'b0) begin
            errors++; $display("FAIL mid_mem_kept got %h/%b exp 00500093/0", instr, flt);
        end
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        req_pc    = '0;
        rsp_ready = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;
        m_out     = 1'b0;
        m_due     = 0;
        m_pc      = '0;
        m_instr   = '0;
        m_fault   = 1'b0;
        m_cnt     = '0;
        cyc       = 0;
        exp_valid = 1'b0;
        exp_ready = 1'b1;

        test_reset();
        test_load_first_fetch();
        test_streaming();
        test_backpressure();
        test_out_of_range();
        test_collision();
        test_random();
        test_reset_mid();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
